// File: rtl/graph_pkg.sv
// Shared types and constants for the arbitrage graph pipeline.
package graph_pkg;
  localparam int NEDGE = 4;
  localparam int VW    = 7;
  localparam int DW    = 25;
  localparam int EW    = 32;

  typedef logic signed [DW-1:0] dist_t;

  typedef struct packed {
    logic [VW-1:0] dst;
    dist_t         weight;
  } edge_t;

  localparam dist_t INF     = 25'h0FFFFFF;
  localparam dist_t NEG_MIN = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_CMP,
    S_EMIT,
    S_FIN
  } state_t;
endpackage

// File: rtl/sat_add.sv
// Saturating signed DW-bit adder; anything at or above INF reads as INF.
module sat_add
  import graph_pkg::*;
(
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] b,
  output logic signed [DW-1:0] sum
);
  localparam logic signed [DW:0] HI = {1'b0, INF};
  localparam logic signed [DW:0] LO = {1'b1, NEG_MIN};

  logic signed [DW:0] wide;

  assign wide = {a[DW-1], a} + {b[DW-1], b};

  always_comb begin
    if (wide >= HI)     sum = INF;
    else if (wide < LO) sum = NEG_MIN;
    else                sum = wide[DW-1:0];
  end
endmodule

// File: rtl/edge_relax_unit.sv
// Serial Bellman-Ford relaxation over one sorted bundle of up to NEDGE edges.
//
//   state  | meaning
//   IDLE   | ready for a bundle
//   LOOKUP | read destination distance from RAM
//   CMP    | compare candidate against RAM result
//   EMIT   | hold update until the writer takes it
//   FIN    | one-cycle done pulse
module edge_relax_unit
  import graph_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NEDGE*EW-1:0]   in_edges,
  input  logic [2:0]            in_cnt,
  input  logic [DW-1:0]         src_dist,
  output logic                  rd_en,
  output logic [VW-1:0]         rd_addr,
  input  logic [DW-1:0]         rd_data,
  output logic                  upd_valid,
  input  logic                  upd_ready,
  output logic [VW-1:0]         upd_vertex,
  output logic [DW-1:0]         upd_dist,
  output logic                  done,
  output logic [15:0]           relax_cnt
);
  localparam logic [2:0] NEDGE3 = 3'(NEDGE);

  state_t              state, state_nxt;
  logic [NEDGE*EW-1:0] edges_q;
  logic [2:0]          cnt_q;
  dist_t               src_q;
  logic [2:0]          idx_q;
  edge_t               cur_edge;
  dist_t               cand;
  logic                better;
  logic                last;

  assign cur_edge = edges_q[idx_q[1:0]*EW +: EW];
  assign better   = cand < $signed(rd_data);
  assign last     = (idx_q + 3'd1) >= cnt_q;

  sat_add u_sat_add (
    .a   (src_q),
    .b   (cur_edge.weight),
    .sum (cand)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:
        if (in_valid)
          state_nxt = (in_cnt == 3'd0 || $signed(src_dist) == INF) ? S_FIN : S_LOOKUP;
      S_LOOKUP: state_nxt = S_CMP;
      S_CMP:
        if (better)    state_nxt = S_EMIT;
        else           state_nxt = last ? S_FIN : S_LOOKUP;
      S_EMIT:
        if (upd_ready) state_nxt = last ? S_FIN : S_LOOKUP;
      S_FIN:    state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    rd_en     = 1'b0;
    rd_addr   = '0;
    upd_valid = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE:   in_ready  = 1'b1;
      S_LOOKUP: begin
        rd_en   = 1'b1;
        rd_addr = cur_edge.dst;
      end
      S_EMIT:   upd_valid = 1'b1;
      S_FIN:    done      = 1'b1;
      default:  ;
    endcase
  end

  // Bundle holding registers, edge index and the registered update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      edges_q    <= '0;
      cnt_q      <= '0;
      src_q      <= '0;
      idx_q      <= '0;
      upd_vertex <= '0;
      upd_dist   <= '0;
      relax_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE:
          if (in_valid) begin
            edges_q <= in_edges;
            cnt_q   <= (in_cnt > NEDGE3) ? NEDGE3 : in_cnt;
            src_q   <= src_dist;
            idx_q   <= '0;
          end
        S_CMP:
          if (better) begin
            upd_vertex <= cur_edge.dst;
            upd_dist   <= cand;
          end else begin
            idx_q <= idx_q + 3'd1;
          end
        S_EMIT:
          if (upd_ready) begin
            relax_cnt <= relax_cnt + 16'd1;
            idx_q     <= idx_q + 3'd1;
          end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/edge_relax_unit.md
Name: edge_relax_unit

Overview:
- Consumer of the 4-edge sorted bundles produced by the edge sorting network: walks one bundle serially, in sorted order, and performs the Bellman-Ford relaxation for each edge.
- Per edge: reads the current destination distance from the vertex-distance RAM (1-cycle read port), forms candidate = src_dist + edge weight, and emits an update when the candidate is smaller.
- Sits between the sorter and the distance-table writer in the arbitrage graph pipeline.

Parameters:
- NEDGE, 4, edges per bundle.
- VW, 7, vertex index width.
- DW, 25, distance/weight width (two's complement).
- EW, 32, edge word width.

Ports:
- clk  in  1  clock.
- reset  in  1  async, active-high.
- in_valid  in  1  bundle offered.
- in_ready  out  1  unit can accept a bundle.
- in_edges  in  NEDGE*EW  edge words; edge i at bits [i*EW +: EW]; word = {dst[VW-1:0], weight[DW-1:0]}.
- in_cnt  in  3  number of valid edges, 0..4; the lowest indices are valid.
- src_dist  in  DW  source vertex distance, captured with the bundle.
- rd_en  out  1  distance RAM read strobe.
- rd_addr  out  VW  vertex to read.
- rd_data  in  DW  read result, valid exactly 1 cycle after rd_en.
- upd_valid  out  1  relaxation update offered.
- upd_ready  in  1  writer accepts the update.
- upd_vertex  out  VW  vertex to update.
- upd_dist  out  DW  new distance.
- done  out  1  one-cycle pulse when the bundle is finished.
- relax_cnt  out  16  running count of accepted updates; wraps at 2^16.

Behaviour:
- Reset (asynchronous, active-high) values: state IDLE, in_ready=1, rd_en=0, rd_addr=0, upd_valid=0, upd_vertex=0, upd_dist=0, done=0, relax_cnt=0.
- Reset mid-operation discards the held bundle and any pending update; no partial update is emitted.
- INF = 25'h0FFFFFF, the largest positive value.
- States: IDLE, LOOKUP, CMP, EMIT, FIN.
- IDLE:
  - in_ready=1.
  - On in_valid: latch edges, in_cnt, src_dist, and clear idx.
  - If in_cnt==0 or src_dist==INF, go to FIN; otherwise go to LOOKUP.
- LOOKUP: rd_en=1 and rd_addr=dst[idx] for exactly one cycle, then CMP.
- CMP:
  - cand = src_dist + weight[idx], computed at DW+1 bits and saturated to the signed DW range.
  - Positive overflow and any result >= INF clamp to INF. Negative overflow clamps to the most negative value.
  - If cand < rd_data (signed compare): register upd_vertex=dst[idx] and upd_dist=cand, then go to EMIT.
  - Otherwise advance idx: go to LOOKUP if idx+1 < cnt, else FIN.
- EMIT:
  - upd_valid=1; upd_vertex and upd_dist stay stable until the handshake.
  - On upd_ready: relax_cnt += 1, upd_valid drops the next cycle, and idx advances as in CMP.
  - upd_ready held low stalls the unit indefinitely.
- FIN: done=1 for one cycle, then IDLE. in_ready=0 in FIN, so the earliest next accept is the cycle after done.
- Throughput: 2 cycles per non-updating edge, 3+ cycles per updating edge.
- Latency example: bundle accepted at cycle 0, first rd_en at cycle 1, first possible upd_valid at cycle 3.
- Edges are processed strictly in index order 0..cnt-1.
- Consecutive edges to the same vertex each use their own fresh RAM read; no internal forwarding, since the downstream writer commits before the next read is issued.
- in_cnt > NEDGE is treated as NEDGE.

Decomposition:
- Shared package graph_pkg: VW, DW, EW, NEDGE, INF, an edge_t struct {dst, weight}, and a dist_t typedef.
- One sub-module, sat_add: combinational saturating signed DW-bit adder with INF clamp. The FSM, index counter and holding registers stay in edge_relax_unit.

Test Plan:
- Basic relax: src_dist=10; edges (dst 3, w 5) and (dst 9, w -2), cnt=2; RAM[3]=20, RAM[9]=4.
  -> one update (3, 15); no update for vertex 9 (8 is not < 4); done pulses; relax_cnt=1.
- Negative weight: src_dist=0; 4 edges to vertices 1..4 with w=-1..-4; all RAM entries=INF.
  -> four updates in order (1,-1), (2,-2), (3,-3), (4,-4); relax_cnt=4.
- Backpressure: same as the basic case with upd_ready low for 5 cycles.
  -> upd_valid stays high with (3, 15) stable, no rd_en during the stall, relax_cnt increments only on the handshake.
- Boundaries:
  - in_cnt=0 -> done 1 cycle after accept, no rd_en.
  - src_dist=INF -> no reads and no updates.
  - src_dist=24'hFFFFF0 with w=+100 and RAM=INF -> candidate clamps to INF, no update.
- Reset mid-bundle: assert reset while in EMIT.
  -> upd_valid=0 immediately (asynchronous), relax_cnt=0, in_ready=1 after release; the next bundle is processed normally.
- Duplicate destination: two edges to vertex 5 (w=3, w=1), src_dist=0; RAM[5]=10, and the RAM model updates RAM[5] on each handshake.
  -> updates (5,3) then (5,1).
